dot_product_sequencer: RTL and testbench

DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

---
 rtl/dot_product_sequencer.sv | 129 ++++++++++++
 tb/tb_dot_product_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// Signed fixed-point 4-element dot product, one shared multiplier stepped over
// the elements, with overflow detection on the rescaled sum.
module dot_product_sequencer #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8
) (
   input  logic                 CLK,
   input  logic                 MasterResetN,
   input  logic                 Clear,
   input  logic                 Enable,
   input  logic                 Start,
   input  logic [4*WIDTH-1:0]   FilaA,
   input  logic [4*WIDTH-1:0]   ColumnaB,
   output logic [WIDTH-1:0]     Resultado,
   output logic                 Listo,
   output logic                 Error
);

   localparam int ACC_W = 2*WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   state_t                    state_q, state_d;
   logic [1:0]                k_q, k_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [4*WIDTH-1:0]        a_q, a_d;
   logic [4*WIDTH-1:0]        b_q, b_d;
   logic [WIDTH-1:0]          res_q, res_d;
   logic                      listo_q, listo_d;
   logic                      error_q, error_d;

   logic signed [WIDTH-1:0]   op_a;
   logic signed [WIDTH-1:0]   op_b;
   logic signed [2*WIDTH-1:0] prod;
   logic [ACC_W-1:0]          prod_ext;
   logic signed [ACC_W-1:0]   scaled;
   logic                      in_range;

   assign op_a     = a_q[k_q*WIDTH +: WIDTH];
   assign op_b     = b_q[k_q*WIDTH +: WIDTH];
   assign prod     = op_a * op_b;
   assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
   assign scaled   = acc_q >>> FRAC;
   // Representable iff every bit from the result sign bit upward agrees.
   assign in_range = (~|scaled[ACC_W-1:WIDTH-1]) | (&scaled[ACC_W-1:WIDTH-1]);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      listo_d = listo_q;
      error_d = error_q;
      if (Clear) begin
         state_d = S_IDLE;
         k_d     = '0;
         acc_d   = '0;
         res_d   = '0;
         listo_d = 1'b0;
         error_d = 1'b0;
      end else if (Enable) begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (Start) begin
                  a_d     = FilaA;
                  b_d     = ColumnaB;
                  acc_d   = '0;
                  k_d     = '0;
                  listo_d = 1'b0;
                  error_d = 1'b0;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               acc_d = acc_q + prod_ext;
               k_d   = k_q + 2'd1;
               if (k_q == 2'd3) state_d = S_CHECK;
            end
            S_CHECK: begin
               if (in_range) begin
                  res_d   = scaled[WIDTH-1:0];
                  listo_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  res_d   = '0;
                  error_d = 1'b1;
                  state_d = S_ERR;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge MasterResetN) begin
      if (!MasterResetN) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         listo_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         listo_q <= listo_d;
         error_q <= error_d;
      end
   end

   assign Resultado = res_q;
   assign Listo     = listo_q;
   assign Error     = error_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: fixed vector table, hand-built timing
// sequences, and randomized operations against an arithmetic reference.
module tb_dot_product_sequencer;

   logic        CLK = 1'b0;
   logic        MasterResetN;
   logic        Clear;
   logic        Enable;
   logic        Start;
   logic [63:0] FilaA;
   logic [63:0] ColumnaB;
   logic [15:0] Resultado;
   logic        Listo;
   logic        Error;

   int checks   = 0;
   int failures = 0;

   dot_product_sequencer #(.WIDTH(16), .FRAC(8)) dut (
      .CLK          (CLK),
      .MasterResetN (MasterResetN),
      .Clear        (Clear),
      .Enable       (Enable),
      .Start        (Start),
      .FilaA        (FilaA),
      .ColumnaB     (ColumnaB),
      .Resultado    (Resultado),
      .Listo        (Listo),
      .Error        (Error)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [15:0] res;
      logic        listo;
      logic        err;
      string       name;
   } vec_t;

   vec_t tbl[10];

   localparam logic [63:0] V_BASIC_A = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
   localparam logic [63:0] V_ONES_B  = {16'h0100, 16'h0100, 16'h0100, 16'h0100};

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic do_start(input logic [63:0] a, input logic [63:0] b);
      FilaA    = a;
      ColumnaB = b;
      Enable   = 1'b1;
      Start    = 1'b1;
      step();
      Start    = 1'b0;
   endtask

   // Reference: exact integer sum of products, floor-scaled, range-checked.
   function automatic void ref_dot(input logic [63:0] a, input logic [63:0] b,
                                   output logic [15:0] res, output logic listo,
                                   output logic err);
      longint sum;
      longint sc;
      logic signed [15:0] x;
      logic signed [15:0] y;
      sum = 0;
      for (int k = 0; k < 4; k++) begin
         x = a[k*16 +: 16];
         y = b[k*16 +: 16];
         sum += longint'(x) * longint'(y);
      end
      sc = sum >>> 8;
      if (sc >= -32768 && sc <= 32767) begin
         res   = sc[15:0];
         listo = 1'b1;
         err   = 1'b0;
      end else begin
         res   = 16'h0000;
         listo = 1'b0;
         err   = 1'b1;
      end
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] e_res;
      logic        e_listo;
      logic        e_err;
      logic        seen;
      logic [63:0] ra;
      logic [63:0] rb;
      int          en_cnt;
      int          v;

      tbl[0] = '{V_BASIC_A, V_ONES_B, 16'h0A00, 1'b1, 1'b0, "basic"};
      tbl[1] = '{64'h0000_0000_0000_FE80, 64'h0000_0000_0000_0200, 16'hFD00, 1'b1, 1'b0, "neg"};
      tbl[2] = '{64'h0000_0000_0000_FF00, 64'h0000_0000_0000_FE00, 16'h0200, 1'b1, 1'b0, "negneg"};
      tbl[3] = '{64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_0100, 16'h7FFF, 1'b1, 1'b0, "max"};
      tbl[4] = '{64'h0000_0000_0000_8000, 64'h0000_0000_0000_0100, 16'h8000, 1'b1, 1'b0, "min"};
      tbl[5] = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0080, 16'hFFFF, 1'b1, 1'b0, "floor"};
      tbl[6] = '{64'h0200_0000_0000_0000, 64'hFF00_0000_0000_0000, 16'hFE00, 1'b1, 1'b0, "lane3"};
      tbl[7] = '{64'h0000_0000_0001_7FFF, 64'h0000_0000_0100_0100, 16'h0000, 1'b0, 1'b1, "over"};
      tbl[8] = '{64'h0000_0000_FFFF_8000, 64'h0000_0000_0100_0100, 16'h0000, 1'b0, 1'b1, "under"};
      tbl[9] = '{64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 16'h0000, 1'b0, 1'b1, "sat"};

      MasterResetN = 1'b0;
      Clear        = 1'b0;
      Enable       = 1'b0;
      Start        = 1'b0;
      FilaA        = '0;
      ColumnaB     = '0;
      #3;
      check("reset_res", Resultado, 0);
      check("reset_flags", {Listo, Error}, 0);
      #10 MasterResetN = 1'b1;
      step();

      // Fixed vectors; the first also exercises the first Start after reset.
      for (int i = 0; i < 10; i++) begin
         do_start(tbl[i].a, tbl[i].b);
         repeat (4) step();
         check({tbl[i].name, "_early"}, {Listo, Error}, 0);
         step();
         check({tbl[i].name, "_res"}, Resultado, tbl[i].res);
         check({tbl[i].name, "_listo"}, Listo, tbl[i].listo);
         check({tbl[i].name, "_err"}, Error, tbl[i].err);
      end

      Clear = 1'b1;
      step();
      Clear = 1'b0;
      check("clear_after_err", {Resultado, Listo, Error}, 0);
      repeat (6) step();
      check("idle_after_clear", {Listo, Error}, 0);

      // Stall for three cycles after the second RUN edge; inputs zeroed after Start.
      do_start(V_BASIC_A, V_ONES_B);
      FilaA    = '0;
      ColumnaB = '0;
      repeat (2) step();
      Enable = 1'b0;
      repeat (3) step();
      Enable = 1'b1;
      repeat (2) step();
      check("stall_early", {Listo, Error}, 0);
      step();
      check("stall_listo", Listo, 1);
      check("stall_res", Resultado, 16'h0A00);
      check("stall_err", Error, 0);

      // Asynchronous reset mid-RUN while Resultado still holds 0x0A00.
      do_start(V_BASIC_A, V_ONES_B);
      repeat (2) step();
      #2 MasterResetN = 1'b0;
      #1;
      check("async_rst_res", Resultado, 0);
      check("async_rst_flags", {Listo, Error}, 0);
      #3 MasterResetN = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         seen = seen | Listo | Error;
      end
      check("no_result_after_rst", seen, 0);

      // Clear and Start together in DONE: Clear wins.
      do_start(V_BASIC_A, V_ONES_B);
      repeat (5) step();
      check("pre_clear_listo", Listo, 1);
      Clear = 1'b1;
      Start = 1'b1;
      step();
      Clear = 1'b0;
      Start = 1'b0;
      check("clear_start_out", {Resultado, Listo, Error}, 0);
      repeat (6) step();
      check("clear_start_idle", {Listo, Error}, 0);

      // Clear acts even with Enable low, aborting a run.
      do_start(V_BASIC_A, V_ONES_B);
      step();
      Enable = 1'b0;
      Clear  = 1'b1;
      step();
      Clear  = 1'b0;
      Enable = 1'b1;
      repeat (6) step();
      check("clear_disabled", {Resultado, Listo, Error}, 0);

      // Start held high through RUN/CHECK with changing inputs: one result.
      FilaA    = V_BASIC_A;
      ColumnaB = V_ONES_B;
      Enable   = 1'b1;
      Start    = 1'b1;
      step();
      FilaA    = 64'h7FFF_7FFF_7FFF_7FFF;
      ColumnaB = 64'h7FFF_7FFF_7FFF_7FFF;
      repeat (5) step();
      Start = 1'b0;
      check("held_start_listo", Listo, 1);
      check("held_start_res", Resultado, 16'h0A00);
      FilaA = '0;
      Start = 1'b1;
      step();
      Start = 1'b0;
      check("restart_drop", Listo, 0);
      repeat (4) step();
      check("restart_early", Listo, 0);
      step();
      check("restart_listo", Listo, 1);
      check("restart_res", Resultado, 0);

      // Randomized operations with random stalls and stray Start pulses.
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < 4; k++) begin
            if (n % 2 == 0) begin
               v = $urandom_range(0, 4095) - 2048;
               ra[k*16 +: 16] = 16'(v);
               v = $urandom_range(0, 4095) - 2048;
               rb[k*16 +: 16] = 16'(v);
            end else begin
               ra[k*16 +: 16] = 16'($urandom);
               rb[k*16 +: 16] = 16'($urandom);
            end
         end
         ref_dot(ra, rb, e_res, e_listo, e_err);
         do_start(ra, rb);
         FilaA    = {$urandom, $urandom};
         ColumnaB = {$urandom, $urandom};
         en_cnt   = 0;
         for (int c = 0; c < 60 && en_cnt < 5; c++) begin
            Enable = ($urandom_range(0, 3) != 0);
            Start  = 1'($urandom_range(0, 1));
            step();
            if (Enable) en_cnt++;
            if (en_cnt < 5) check("rnd_early", {Listo, Error}, 0);
         end
         Start  = 1'b0;
         Enable = 1'b1;
         check("rnd_latency", (en_cnt == 5), 1);
         check("rnd_res", Resultado, e_res);
         check("rnd_flags", {Listo, Error}, {e_listo, e_err});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
